ex_stage: RTL and testbench

Execute stage of the five-stage in-order LoongArch pipeline, between the decode stage and the memory stage. It registers the decode bundle and drives the external ALU. It runs a 32-iteration restoring divider for div/mod instructions and issues the data-SRAM request with store byte-lane alignment. It hands the 39-bit result bundle, the 5-bit load-type bus and the PC to the memory stage, and exports a forwarding/stall bus back to decode.

---
 rtl/ex_stage.sv | 213 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: registers the decode bundle, drives the external ALU, runs a
// 32-step restoring divider and issues byte-lane aligned data-SRAM requests.
//
// state     | meaning
// DIV_IDLE  | no divide in progress; operands latched when a divide is resident
// DIV_BUSY  | one restoring step per cycle, div_cnt 0..31
// DIV_DONE  | result held until the instruction moves to the memory stage
module ex_stage (
  input  logic         clk,
  input  logic         reset,
  output logic         es_allowin,
  input  logic         ds_to_es_valid,
  input  logic [31:0]  ds_pc,
  input  logic [126:0] ds_to_es_bus,
  output logic [11:0]  es_alu_op,
  output logic [31:0]  es_alu_src1,
  output logic [31:0]  es_alu_src2,
  input  logic [31:0]  alu_result,
  input  logic         ms_allowin,
  output logic         es_to_ms_valid,
  output logic [31:0]  es_pc,
  output logic [38:0]  es_rf_collect,
  output logic [4:0]   mem_inst_bus,
  output logic [38:0]  es_fwd_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  logic        es_valid;
  logic        es_ready_go;
  logic [3:0]  div_op;
  logic [4:0]  ld_bus;
  logic [2:0]  st_op;
  logic        res_from_mem;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rkd_value;
  logic [31:0] es_result;
  logic        es_blocked;

  div_state_t  div_state, div_state_nxt;
  logic        div_start;
  logic [4:0]  div_cnt;
  logic [31:0] div_rem;
  logic [31:0] div_quo;
  logic [31:0] div_dsr;
  logic        div_neg_q;
  logic        div_neg_r;
  logic        div_zero;

  logic        is_div;
  logic        div_signed;
  logic        sel_quo;
  logic        src1_neg;
  logic        src2_neg;
  logic [31:0] abs_src1;
  logic [31:0] abs_src2;
  logic [32:0] step_tmp;
  logic [32:0] step_diff;
  logic        step_ge;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] div_result;

  logic        mem_op;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;

  assign es_allowin      = ~es_valid | (es_ready_go & ms_allowin);
  assign es_to_ms_valid  = es_valid & es_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid     <= 1'b0;
      es_pc        <= 32'h0;
      div_op       <= 4'h0;
      ld_bus       <= 5'h0;
      st_op        <= 3'h0;
      res_from_mem <= 1'b0;
      rf_we        <= 1'b0;
      rf_waddr     <= 5'h0;
      es_alu_op    <= 12'h0;
      es_alu_src1  <= 32'h0;
      es_alu_src2  <= 32'h0;
      rkd_value    <= 32'h0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
      if (ds_to_es_valid) begin
        es_pc        <= ds_pc;
        div_op       <= ds_to_es_bus[126:123];
        ld_bus       <= ds_to_es_bus[122:118];
        st_op        <= ds_to_es_bus[117:115];
        res_from_mem <= ds_to_es_bus[114];
        rf_we        <= ds_to_es_bus[113];
        rf_waddr     <= ds_to_es_bus[112:108];
        es_alu_op    <= ds_to_es_bus[107:96];
        es_alu_src1  <= ds_to_es_bus[95:64];
        es_alu_src2  <= ds_to_es_bus[63:32];
        rkd_value    <= ds_to_es_bus[31:0];
      end
    end
  end

  // div_op = {div.w, mod.w, div.wu, mod.wu}
  assign is_div     = |div_op;
  assign div_signed = div_op[3] | div_op[2];
  assign sel_quo    = div_op[3] | div_op[1];
  assign src1_neg   = div_signed & es_alu_src1[31];
  assign src2_neg   = div_signed & es_alu_src2[31];
  assign abs_src1   = src1_neg ? -es_alu_src1 : es_alu_src1;
  assign abs_src2   = src2_neg ? -es_alu_src2 : es_alu_src2;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_state <= DIV_IDLE;
    end else begin
      div_state <= div_state_nxt;
    end
  end

  always_comb begin
    div_state_nxt = div_state;
    div_start     = 1'b0;
    case (div_state)
      DIV_IDLE: begin
        if (es_valid & is_div) begin
          div_state_nxt = DIV_BUSY;
          div_start     = 1'b1;
        end
      end
      DIV_BUSY: begin
        if (div_cnt == 5'd31) begin
          div_state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (es_valid & ms_allowin) begin
          div_state_nxt = DIV_IDLE;
        end
      end
      default: div_state_nxt = DIV_IDLE;
    endcase
  end

  // Partial remainder stays below the divisor, so 33 bits hold the shifted value.
  assign step_tmp  = {div_rem, div_quo[31]};
  assign step_diff = step_tmp - {1'b0, div_dsr};
  assign step_ge   = ~step_diff[32];

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= 5'd0;
      div_rem   <= 32'h0;
      div_quo   <= 32'h0;
      div_dsr   <= 32'h0;
      div_neg_q <= 1'b0;
      div_neg_r <= 1'b0;
      div_zero  <= 1'b0;
    end else if (div_start) begin
      div_cnt   <= 5'd0;
      div_rem   <= 32'h0;
      div_quo   <= abs_src1;
      div_dsr   <= abs_src2;
      div_neg_q <= src1_neg ^ src2_neg;
      div_neg_r <= src1_neg;
      div_zero  <= (es_alu_src2 == 32'h0);
    end else if (div_state == DIV_BUSY) begin
      div_quo <= {div_quo[30:0], step_ge};
      div_rem <= step_ge ? step_diff[31:0] : step_tmp[31:0];
      div_cnt <= div_cnt + 5'd1;
    end
  end

  // A zero divisor leaves |src1| in the remainder, which re-signs back to src1.
  assign quo_fix    = div_zero ? 32'hFFFF_FFFF : (div_neg_q ? -div_quo : div_quo);
  assign rem_fix    = div_neg_r ? -div_rem : div_rem;
  assign div_result = sel_quo ? quo_fix : rem_fix;

  assign es_ready_go   = ~is_div | (div_state == DIV_DONE);
  assign es_result     = is_div ? div_result : alu_result;
  assign es_blocked    = es_valid & (res_from_mem | (is_div & ~es_ready_go));
  assign es_rf_collect = {res_from_mem, rf_we, rf_waddr, es_result};
  assign es_fwd_bus    = {es_valid & rf_we, rf_waddr, es_result, es_blocked};
  assign mem_inst_bus  = ld_bus;

  assign mem_op         = (|ld_bus) | (|st_op);
  assign data_sram_en   = es_valid & ms_allowin & mem_op;
  assign data_sram_addr = alu_result;

  // st_op = {st.w, st.h, st.b}
  always_comb begin
    st_we    = 4'b0000;
    st_wdata = 32'h0;
    if (st_op[2]) begin
      st_we    = 4'b1111;
      st_wdata = rkd_value;
    end else if (st_op[1]) begin
      st_we    = alu_result[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{rkd_value[15:0]}};
    end else if (st_op[0]) begin
      st_we    = 4'b0001 << alu_result[1:0];
      st_wdata = {4{rkd_value[7:0]}};
    end
  end

  assign data_sram_we    = data_sram_en ? st_we : 4'b0000;
  assign data_sram_wdata = st_wdata;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset state, divider results and latency,
// store lane alignment, load stall and back-to-back handshake ordering.
module tb_ex_stage;

  logic         clk;
  logic         reset;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [31:0]  ds_pc;
  logic [126:0] ds_to_es_bus;
  logic [11:0]  es_alu_op;
  logic [31:0]  es_alu_src1;
  logic [31:0]  es_alu_src2;
  logic [31:0]  alu_result;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [31:0]  es_pc;
  logic [38:0]  es_rf_collect;
  logic [4:0]   mem_inst_bus;
  logic [38:0]  es_fwd_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] DIV_W  = 4'b1000;
  localparam logic [3:0] MOD_W  = 4'b0100;
  localparam logic [3:0] DIV_WU = 4'b0010;
  localparam logic [3:0] MOD_WU = 4'b0001;

  ex_stage dut (
    .clk             (clk),
    .reset           (reset),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_pc           (ds_pc),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_alu_op       (es_alu_op),
    .es_alu_src1     (es_alu_src1),
    .es_alu_src2     (es_alu_src2),
    .alu_result      (alu_result),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_pc           (es_pc),
    .es_rf_collect   (es_rf_collect),
    .mem_inst_bus    (mem_inst_bus),
    .es_fwd_bus      (es_fwd_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  // External ALU stand-in: add only.
  assign alu_result = es_alu_src1 + es_alu_src2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [126:0] mk_bus(input logic [3:0] dop, input logic [4:0] ld,
                                          input logic [2:0] st, input logic rfm,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] s1, input logic [31:0] s2,
                                          input logic [31:0] rkd);
    return {dop, ld, st, rfm, we, wa, 12'h001, s1, s2, rkd};
  endfunction

  task automatic do_div(input string tag, input logic [3:0] dop, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int stall);
    int n;
    ms_allowin     = (stall == 0);
    ds_to_es_bus   = mk_bus(dop, 5'b0, 3'b0, 1'b0, 1'b1, 5'd4, a, b, 32'h0);
    ds_pc          = 32'h1c00_0100;
    ds_to_es_valid = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    chk({tag, "_blk"}, 64'(es_fwd_bus[0]), 64'd1);
    n = 0;
    while (!es_to_ms_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_res"}, 64'(es_rf_collect[31:0]), 64'(exp));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_v"}, 64'(es_to_ms_valid), 64'd1);
      chk({tag, "_hold_r"}, 64'(es_rf_collect[31:0]), 64'(exp));
      chk({tag, "_hold_a"}, 64'(es_allowin), 64'd0);
    end
    ms_allowin = 1'b1;
    #1;
    chk({tag, "_allow"}, 64'(es_allowin), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_gone"}, 64'(es_to_ms_valid), 64'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] st, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] rkd,
                          input logic [3:0] exp_we, input logic [31:0] exp_wdata);
    ms_allowin     = 1'b1;
    ds_to_es_bus   = mk_bus(4'b0, 5'b0, st, 1'b0, 1'b0, 5'd0, base, off, rkd);
    ds_pc          = 32'h1c00_0200;
    ds_to_es_valid = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    chk({tag, "_en"}, 64'(data_sram_en), 64'd1);
    chk({tag, "_we"}, 64'(data_sram_we), 64'(exp_we));
    chk({tag, "_wdata"}, 64'(data_sram_wdata), 64'(exp_wdata));
    chk({tag, "_addr"}, 64'(data_sram_addr), 64'(base + off));
    @(posedge clk); #1;
  endtask

  localparam int NB2B = 8;
  localparam logic [9:0] ALLOW_PAT = 10'b1011001101;

  function automatic logic [31:0] b2b_pc(input int idx);
    return 32'h1c00_1000 + 32'(idx * 4);
  endfunction

  function automatic logic [31:0] b2b_res(input int idx);
    return 32'(idx * 256) + 32'h1 + 32'h20;
  endfunction

  initial begin
    int idx_off;
    int idx_done;
    int cyc;
    logic occ;
    logic exp_allow;

    reset          = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_pc          = 32'h0;
    ds_to_es_bus   = '0;
    ms_allowin     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_allowin", 64'(es_allowin), 64'd1);
    chk("rst_tomsv", 64'(es_to_ms_valid), 64'd0);
    chk("rst_pc", 64'(es_pc), 64'd0);
    chk("rst_collect", 64'(es_rf_collect), 64'd0);
    chk("rst_fwd", 64'(es_fwd_bus), 64'd0);
    chk("rst_mem_inst", 64'(mem_inst_bus), 64'd0);
    chk("rst_en", 64'(data_sram_en), 64'd0);
    chk("rst_we", 64'(data_sram_we), 64'd0);
    chk("rst_wdata", 64'(data_sram_wdata), 64'd0);
    chk("rst_aluop", 64'(es_alu_op), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_div("div_w_neg", DIV_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    do_div("mod_w_neg", MOD_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    do_div("div_wu", DIV_WU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 0);
    do_div("mod_wu_z", MOD_WU, 32'd7, 32'd0, 32'd7, 2);
    do_div("div_w_z", DIV_W, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    do_div("div_w_ovf", DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_div("mod_w_ovf", MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    do_div("mod_w_z_neg", MOD_W, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 0);

    // Reset in the middle of a divide.
    ms_allowin     = 1'b1;
    ds_to_es_bus   = mk_bus(DIV_W, 5'b0, 3'b0, 1'b0, 1'b1, 5'd4, 32'd100, 32'd3, 32'h0);
    ds_to_es_valid = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mrst_allowin", 64'(es_allowin), 64'd1);
    chk("mrst_tomsv", 64'(es_to_ms_valid), 64'd0);
    chk("mrst_en", 64'(data_sram_en), 64'd0);
    chk("mrst_fwd", 64'(es_fwd_bus), 64'd0);
    @(posedge clk); #1;
    do_div("after_rst", DIV_W, 32'd100, 32'd3, 32'd33, 0);

    do_store("st_b", 3'b001, 32'h1000, 32'h3, 32'h1234_5678, 4'b1000, 32'h7878_7878);
    do_store("st_h", 3'b010, 32'h1000, 32'h2, 32'h1234_5678, 4'b1100, 32'h5678_5678);
    do_store("st_h_lo", 3'b010, 32'h1000, 32'h0, 32'h1234_5678, 4'b0011, 32'h5678_5678);
    do_store("st_w", 3'b100, 32'h2000, 32'h4, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE);

    // Load held by the memory stage for three cycles.
    ms_allowin     = 1'b0;
    ds_to_es_bus   = mk_bus(4'b0, 5'b01000, 3'b0, 1'b1, 1'b1, 5'd5, 32'h3000, 32'h2, 32'h0);
    ds_pc          = 32'h1c00_0300;
    ds_to_es_valid = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ld_stall_en", 64'(data_sram_en), 64'd0);
      chk("ld_stall_blk", 64'(es_fwd_bus[0]), 64'd1);
      chk("ld_stall_allow", 64'(es_allowin), 64'd0);
      @(posedge clk); #1;
    end
    ms_allowin = 1'b1;
    #1;
    chk("ld_rel_en", 64'(data_sram_en), 64'd1);
    chk("ld_rel_we", 64'(data_sram_we), 64'd0);
    chk("ld_rel_blk", 64'(es_fwd_bus[0]), 64'd1);
    chk("ld_rel_inst", 64'(mem_inst_bus), 64'b01000);
    chk("ld_rel_addr", 64'(data_sram_addr), 64'h3002);
    chk("ld_rel_fwd_we", 64'(es_fwd_bus[38:33]), 64'({1'b1, 5'd5}));
    @(posedge clk); #1;
    chk("ld_after_en", 64'(data_sram_en), 64'd0);

    // Back-to-back adds with the memory stage toggling its allowin.
    idx_off  = 0;
    idx_done = 0;
    occ      = 1'b0;
    cyc      = 0;
    while (idx_done < NB2B && cyc < 80) begin
      ms_allowin     = ALLOW_PAT[cyc % 10];
      ds_to_es_valid = (idx_off < NB2B);
      ds_pc          = b2b_pc(idx_off);
      ds_to_es_bus   = mk_bus(4'b0, 5'b0, 3'b0, 1'b0, 1'b1, 5'd7,
                              32'(idx_off * 256) + 32'h1, 32'h20, 32'h0);
      #1;
      exp_allow = ~occ | ms_allowin;
      chk("b2b_allowin", 64'(es_allowin), 64'(exp_allow));
      chk("b2b_tomsv", 64'(es_to_ms_valid), 64'(occ));
      if (occ && ms_allowin) begin
        chk("b2b_pc", 64'(es_pc), 64'(b2b_pc(idx_done)));
        chk("b2b_res", 64'(es_rf_collect[31:0]), 64'(b2b_res(idx_done)));
        idx_done++;
      end
      if (exp_allow) begin
        occ = (idx_off < NB2B);
        if (idx_off < NB2B) idx_off++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ds_to_es_valid = 1'b0;
    chk("b2b_count", 64'(idx_done), 64'(NB2B));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
